elbeth_load_store_unit: RTL and testbench

Memory-stage load/store unit for the ELBETH core. It sits directly upstream of the load zero/sign-extension stage. It accepts one load or store per instruction from the MEM pipeline stage, checks alignment, and drives a word-addressed data-memory bus with a req/ack handshake and byte strobes. It returns load data right-aligned to bit 0, which the extension stage then sizes and sign- or zero-extends. It stalls the pipeline for the duration of each access.

---
 rtl/elbeth_load_store_unit.sv | 179 +++++++++++++++++
 tb/tb_elbeth_load_store_unit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/elbeth_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : elbeth_load_store_unit
// Brief    : MEM-stage load/store unit. Checks alignment, drives a
//            word-addressed req/ack data bus with byte strobes, returns load
//            data right-aligned and stalls the pipeline during each access.
// Revision : 1.0 - initial release
// ============================================================================
module elbeth_load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  ctrl_data_size,
  output logic        mem_stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        misaligned_exc,
  output logic        bus_err,
  output logic [31:0] exc_addr,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_err
);

  // Access-size encodings shared with the core's definitions header.
  localparam logic [3:0] SIZE_WORD     = 4'b1111;
  localparam logic [3:0] SIZE_HALFWORD = 4'b0011;
  localparam logic [3:0] SIZE_BYTE     = 4'b0001;

  // Counter just wide enough to reach TIMEOUT_CYCLES (1 bit when disabled).
  localparam int unsigned CNT_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam bit          TO_EN    = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic [31:0]        addr_q;
  logic               we_q;
  logic [3:0]         wstrb_q;
  logic [31:0]        wdata_q;
  logic               req_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [31:0]        load_data_q;
  logic               load_valid_q;
  logic               misaligned_q;
  logic               bus_err_q;
  logic [31:0]        exc_addr_q;

  logic               req_present;
  logic               fault_d;
  logic [3:0]         wstrb_d;
  logic [31:0]        wdata_d;

  assign req_present = mem_read | mem_write;

  // Alignment check and store lane formatting for the incoming request.
  always_comb begin
    fault_d = 1'b0;
    wstrb_d = 4'b0000;
    wdata_d = mem_wdata;
    case (ctrl_data_size)
      SIZE_BYTE: begin
        wstrb_d = 4'b0001 << mem_addr[1:0];
        wdata_d = {4{mem_wdata[7:0]}};
      end
      SIZE_HALFWORD: begin
        fault_d = mem_addr[0];
        wstrb_d = 4'b0011 << mem_addr[1:0];
        wdata_d = {2{mem_wdata[15:0]}};
      end
      SIZE_WORD: begin
        fault_d = (mem_addr[1:0] != 2'b00);
        wstrb_d = 4'b1111;
        wdata_d = mem_wdata;
      end
      default: fault_d = 1'b1;
    endcase
  end

  // Access FSM with registered bus signals, result and exception pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= 32'd0;
      we_q         <= 1'b0;
      wstrb_q      <= 4'b0000;
      wdata_q      <= 32'd0;
      req_q        <= 1'b0;
      cnt_q        <= '0;
      load_data_q  <= 32'd0;
      load_valid_q <= 1'b0;
      misaligned_q <= 1'b0;
      bus_err_q    <= 1'b0;
      exc_addr_q   <= 32'd0;
    end else begin
      // Pulses last exactly the one DONE cycle.
      load_valid_q <= 1'b0;
      misaligned_q <= 1'b0;
      bus_err_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_present) begin
            if (fault_d) begin
              misaligned_q <= 1'b1;
              exc_addr_q   <= mem_addr;
              state_q      <= S_DONE;
            end else begin
              addr_q  <= mem_addr;
              we_q    <= mem_write;
              wstrb_q <= mem_write ? wstrb_d : 4'b0000;
              wdata_q <= wdata_d;
              req_q   <= 1'b1;
              cnt_q   <= '0;
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (dmem_ack) begin
            req_q   <= 1'b0;
            state_q <= S_DONE;
            if (dmem_err) begin
              bus_err_q  <= 1'b1;
              exc_addr_q <= addr_q;
            end else if (!we_q) begin
              load_valid_q <= 1'b1;
              load_data_q  <= dmem_rdata >> {addr_q[1:0], 3'b000};
            end
          end else if (TO_EN && (cnt_q == TO_LIMIT)) begin
            req_q      <= 1'b0;
            bus_err_q  <= 1'b1;
            exc_addr_q <= addr_q;
            state_q    <= S_DONE;
          end else if (TO_EN) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_DONE: begin
          // The request still on the inputs belongs to this access; drop it.
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Stall while a request waits in IDLE or the bus access is outstanding.
  always_comb begin
    mem_stall = ~rst & (((state_q == S_IDLE) & req_present) | (state_q == S_WAIT));
  end

  assign load_data      = load_data_q;
  assign load_valid     = load_valid_q;
  assign misaligned_exc = misaligned_q;
  assign bus_err        = bus_err_q;
  assign exc_addr       = exc_addr_q;
  assign dmem_req       = req_q;
  assign dmem_we        = we_q;
  assign dmem_addr      = {addr_q[31:2], 2'b00};
  assign dmem_wdata     = wdata_q;
  assign dmem_wstrb     = wstrb_q;

endmodule
`default_nettype wire

// File: tb/tb_elbeth_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_elbeth_load_store_unit
// Brief    : Directed self-checking bench for elbeth_load_store_unit.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_elbeth_load_store_unit;

  localparam logic [3:0] SZ_WORD = 4'b1111;
  localparam logic [3:0] SZ_HALF = 4'b0011;
  localparam logic [3:0] SZ_BYTE = 4'b0001;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  ctrl_data_size;
  logic        mem_stall;
  logic [31:0] load_data;
  logic        load_valid, misaligned_exc, bus_err;
  logic [31:0] exc_addr;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        dmem_err;

  int n_checks = 0;
  int n_fails  = 0;

  elbeth_load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .ctrl_data_size (ctrl_data_size),
    .mem_stall      (mem_stall),
    .load_data      (load_data),
    .load_valid     (load_valid),
    .misaligned_exc (misaligned_exc),
    .bus_err        (bus_err),
    .exc_addr       (exc_addr),
    .dmem_req       (dmem_req),
    .dmem_we        (dmem_we),
    .dmem_addr      (dmem_addr),
    .dmem_wdata     (dmem_wdata),
    .dmem_wstrb     (dmem_wstrb),
    .dmem_ack       (dmem_ack),
    .dmem_rdata     (dmem_rdata),
    .dmem_err       (dmem_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; land 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_read  = 1'b0;
    mem_write = 1'b0;
    dmem_ack  = 1'b0;
    dmem_err  = 1'b0;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] sz);
    mem_read       = rd;
    mem_write      = wr;
    mem_addr       = a;
    mem_wdata      = wd;
    ctrl_data_size = sz;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    mem_addr = 32'd0; mem_wdata = 32'd0; ctrl_data_size = SZ_WORD;
    dmem_rdata = 32'd0;
    tick(); tick();
    mem_read = 1'b1; #1;
    check("rst_stall",      {31'd0, mem_stall},  32'd0);
    check("rst_req",        {31'd0, dmem_req},   32'd0);
    check("rst_load_data",  load_data,           32'd0);
    check("rst_pulses",     {29'd0, load_valid, misaligned_exc, bus_err}, 32'd0);
    check("rst_exc_addr",   exc_addr,            32'd0);
    mem_read = 1'b0;
    rst = 1'b0;
    tick();

    // LB from 0x103, ack one cycle after req.
    drive(1'b1, 1'b0, 32'h0000_0103, 32'd0, SZ_BYTE);
    check("lb_stall_T",    {31'd0, mem_stall}, 32'd1);
    tick();
    check("lb_req",        {31'd0, dmem_req},  32'd1);
    check("lb_addr",       dmem_addr,          32'h0000_0100);
    check("lb_wstrb",      {28'd0, dmem_wstrb}, 32'd0);
    check("lb_we",         {31'd0, dmem_we},   32'd0);
    check("lb_stall_T1",   {31'd0, mem_stall}, 32'd1);
    dmem_ack = 1'b1; dmem_rdata = 32'hAABB_CCDD;
    tick();
    dmem_ack = 1'b0; #1;
    check("lb_valid",      {31'd0, load_valid}, 32'd1);
    check("lb_data",       load_data,           32'h0000_00AA);
    check("lb_stall_T2",   {31'd0, mem_stall},  32'd0);
    check("lb_req_drop",   {31'd0, dmem_req},   32'd0);
    mem_read = 1'b0;
    tick();
    check("lb_valid_1cyc", {31'd0, load_valid}, 32'd0);
    check("lb_data_hold",  load_data,           32'h0000_00AA);

    // SH of 0x12345678 to 0x202.
    drive(1'b0, 1'b1, 32'h0000_0202, 32'h1234_5678, SZ_HALF);
    tick();
    check("sh_req",        {31'd0, dmem_req},   32'd1);
    check("sh_we",         {31'd0, dmem_we},    32'd1);
    check("sh_addr",       dmem_addr,           32'h0000_0200);
    check("sh_wstrb",      {28'd0, dmem_wstrb}, 32'h0000_000C);
    check("sh_wdata",      dmem_wdata,          32'h5678_5678);
    dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    tick();
    dmem_ack = 1'b0; #1;
    check("sh_no_valid",   {31'd0, load_valid}, 32'd0);
    check("sh_no_err",     {31'd0, bus_err},    32'd0);
    check("sh_load_hold",  load_data,           32'h0000_00AA);
    mem_write = 1'b0;
    tick();

    // SB of 0x..EF to 0x301: single lane strobe, byte replicated.
    drive(1'b0, 1'b1, 32'h0000_0301, 32'h0000_12EF, SZ_BYTE);
    tick();
    check("sb_wstrb",      {28'd0, dmem_wstrb}, 32'h0000_0002);
    check("sb_wdata",      dmem_wdata,          32'hEFEF_EFEF);
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0; mem_write = 1'b0;
    tick();

    // LW from 0x101: misaligned, no bus cycle.
    drive(1'b1, 1'b0, 32'h0000_0101, 32'd0, SZ_WORD);
    check("lwm_stall_T",   {31'd0, mem_stall},      32'd1);
    tick();
    check("lwm_exc",       {31'd0, misaligned_exc}, 32'd1);
    check("lwm_exc_addr",  exc_addr,                32'h0000_0101);
    check("lwm_no_req",    {31'd0, dmem_req},       32'd0);
    check("lwm_stall_T1",  {31'd0, mem_stall},      32'd0);
    mem_read = 1'b0;
    tick();
    check("lwm_exc_1cyc",  {31'd0, misaligned_exc}, 32'd0);
    check("lwm_no_req2",   {31'd0, dmem_req},       32'd0);

    // Illegal size encoding faults as well.
    drive(1'b1, 1'b0, 32'h0000_0200, 32'd0, 4'b0111);
    tick();
    check("bad_size_exc",  {31'd0, misaligned_exc}, 32'd1);
    mem_read = 1'b0;
    tick();

    // LW from 0x40, ack withheld, timeout of 4.
    drive(1'b1, 1'b0, 32'h0000_0040, 32'd0, SZ_WORD);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check($sformatf("to_req_T%0d", i), {31'd0, dmem_req}, 32'd1);
      check($sformatf("to_noerr_T%0d", i), {31'd0, bus_err}, 32'd0);
    end
    tick();
    tick();
    check("to_bus_err",    {31'd0, bus_err},  32'd1);
    check("to_exc_addr",   exc_addr,          32'h0000_0040);
    check("to_req_drop",   {31'd0, dmem_req}, 32'd0);
    check("to_no_valid",   {31'd0, load_valid}, 32'd0);
    mem_read = 1'b0;
    tick();
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    tick();
    check("to_late_ack_v", {31'd0, load_valid}, 32'd0);
    check("to_late_ack_e", {31'd0, bus_err},    32'd0);
    check("to_late_ack_r", {31'd0, dmem_req},   32'd0);

    // SW to 0x80 answered with an error.
    drive(1'b0, 1'b1, 32'h0000_0080, 32'hCAFE_F00D, SZ_WORD);
    tick();
    check("swe_wstrb",     {28'd0, dmem_wstrb}, 32'h0000_000F);
    check("swe_wdata",     dmem_wdata,          32'hCAFE_F00D);
    dmem_ack = 1'b1; dmem_err = 1'b1;
    tick();
    dmem_ack = 1'b0; dmem_err = 1'b0; #1;
    check("swe_bus_err",   {31'd0, bus_err},    32'd1);
    check("swe_exc_addr",  exc_addr,            32'h0000_0080);
    check("swe_no_valid",  {31'd0, load_valid}, 32'd0);
    mem_write = 1'b0;
    tick();

    // Following LH from 0x86 proceeds normally.
    drive(1'b1, 1'b0, 32'h0000_0086, 32'd0, SZ_HALF);
    tick();
    check("lh_addr",       dmem_addr,          32'h0000_0084);
    check("lh_req",        {31'd0, dmem_req},  32'd1);
    dmem_ack = 1'b1; dmem_rdata = 32'h1122_3344;
    tick();
    dmem_ack = 1'b0; #1;
    check("lh_valid",      {31'd0, load_valid}, 32'd1);
    check("lh_data",       load_data,           32'h0000_1122);
    check("lh_no_err",     {31'd0, bus_err},    32'd0);
    mem_read = 1'b0;
    tick();

    // Reset in the second WAIT cycle, then a late ack; request stays held.
    drive(1'b1, 1'b0, 32'h0000_0010, 32'd0, SZ_WORD);
    tick();
    tick();
    check("rw_req_wait2",  {31'd0, dmem_req}, 32'd1);
    rst = 1'b1; #1;
    check("rw_stall_rst",  {31'd0, mem_stall}, 32'd0);
    tick();
    rst = 1'b0;
    dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF; #1;
    check("rw_req_off",    {31'd0, dmem_req},  32'd0);
    check("rw_no_pulse",   {29'd0, load_valid, misaligned_exc, bus_err}, 32'd0);
    check("rw_stall_idle", {31'd0, mem_stall}, 32'd1);
    tick();
    dmem_ack = 1'b0; #1;
    check("rw_reissue",    {31'd0, dmem_req},   32'd1);
    check("rw_ack_ignored",{31'd0, load_valid}, 32'd0);
    check("rw_addr",       dmem_addr,           32'h0000_0010);
    dmem_ack = 1'b1; dmem_rdata = 32'h5566_7788;
    tick();
    dmem_ack = 1'b0; #1;
    check("rw_valid",      {31'd0, load_valid}, 32'd1);
    check("rw_data",       load_data,           32'h5566_7788);
    mem_read = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
